regfile_op_sequencer: RTL and testbench

Command-driven controller for the 4×16-bit, 2-write/2-read register file. It accepts one operation per valid/ready handshake and sequences the register file's read enables, addresses and write ports through a fixed IDLE→READ→EXEC→WB flow. Results are written back through write port 1, or through both ports for SWAP. It sits between the instruction/control logic and the register file, and is the only driver of the register file's address and enable pins.

---
 rtl/regfile_ctrl_pkg.sv | 9 +
 rtl/regfile_alu.sv | 15 +
 rtl/regfile_op_sequencer.sv | 107 ++++++++++
 tb/tb_regfile_op_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared widths, opcode and state encodings for the register-file sequencer
package regfile_ctrl_pkg;
  localparam int DW = 16;
  localparam int AW = 2;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_SWAP, OP_RSV
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
endpackage

// File: rtl/regfile_alu.sv
// regfile_alu: combinational ALU producing {carry/borrow, result}
module regfile_alu
  import regfile_ctrl_pkg::*;
(
  input  op_e           i_op,
  input  logic [DW-1:0] i_opa,
  input  logic [DW-1:0] i_opb,
  output logic [DW:0]   o_res
);
  assign o_res = i_op == OP_ADD ? {1'b0, i_opa} + {1'b0, i_opb} :
                 i_op == OP_SUB ? {1'b0, i_opa} - {1'b0, i_opb} :
                 i_op == OP_AND ? {1'b0, i_opa & i_opb} :
                 i_op == OP_OR  ? {1'b0, i_opa | i_opb} :
                 i_op == OP_XOR ? {1'b0, i_opa ^ i_opb} : '0;
endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: IDLE->READ->EXEC->WB command sequencer driving a 2R/2W register file
module regfile_op_sequencer
  import regfile_ctrl_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [2:0]    i_cmd_op,
  input  logic [AW-1:0] i_cmd_ra,
  input  logic [AW-1:0] i_cmd_rb,
  input  logic [AW-1:0] i_cmd_rd,
  input  logic [DW-1:0] i_cmd_imm,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_result,
  output logic          o_flag_z,
  output logic          o_flag_c,
  output logic [AW-1:0] o_raa,
  output logic [AW-1:0] o_rab,
  output logic          o_rea,
  output logic          o_reb,
  input  logic [DW-1:0] i_rda,
  input  logic [DW-1:0] i_rdb,
  output logic [AW-1:0] o_wa1,
  output logic [AW-1:0] o_wa2,
  output logic [DW-1:0] o_wd1,
  output logic [DW-1:0] o_wd2,
  output logic          o_we1,
  output logic          o_we2
);
  state_e        r_state, w_next;
  op_e           r_op, w_op;
  logic [AW-1:0] r_ra, r_rb, r_rd;
  logic [DW-1:0] r_imm, r_opa, r_opb, r_res, r_result;
  logic          r_z, r_c, r_errp;
  logic [DW:0]   w_alu;
  logic          w_accept, w_wb, w_swap;
  assign w_op        = op_e'(i_cmd_op);
  assign o_cmd_ready = r_state == S_IDLE && !r_errp;
  assign w_accept    = o_cmd_ready && i_cmd_valid;
  assign w_wb        = r_state == S_WB;
  assign w_swap      = r_op == OP_SWAP;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_op == OP_LDI ? S_WB : w_op == OP_RSV ? S_IDLE : S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_IDLE;
    endcase
  end
  regfile_alu u_alu (.i_op(r_op), .i_opa(r_opa), .i_opb(r_opb), .o_res(w_alu));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_op     <= OP_ADD;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_errp   <= 1'b0;
    end else begin
      r_errp <= w_accept && w_op == OP_RSV;
      if (w_accept) begin
        r_op  <= w_op;
        r_ra  <= i_cmd_ra;
        r_rb  <= i_cmd_rb;
        r_rd  <= i_cmd_rd;
        r_imm <= i_cmd_imm;
      end
      if (r_state == S_READ) begin
        r_opa <= i_rda;
        r_opb <= i_rdb;
      end
      if (r_state == S_EXEC && r_op <= OP_XOR) begin
        r_res <= w_alu[DW-1:0];
        r_z   <= w_alu[DW-1:0] == '0;
        r_c   <= w_alu[DW];
      end
      if (w_wb) r_result <= o_wd1;
    end
  // Register-file pins are decoded from state so an async reset drops them at once
  assign o_rea    = r_state == S_READ;
  assign o_reb    = o_rea;
  assign o_raa    = o_rea ? r_ra : '0;
  assign o_rab    = o_rea ? r_rb : '0;
  assign o_we1    = w_wb;
  assign o_wa1    = !w_wb ? '0 : w_swap ? r_ra : r_rd;
  assign o_wd1    = !w_wb ? '0 : w_swap ? r_opb : r_op == OP_LDI ? r_imm : r_res;
  assign o_we2    = w_wb && w_swap && r_ra != r_rb;
  assign o_wa2    = o_we2 ? r_rb : '0;
  assign o_wd2    = o_we2 ? r_opa : '0;
  assign o_done   = w_wb || r_errp;
  assign o_err    = r_errp;
  assign o_result = r_result;
  assign o_flag_z = r_z;
  assign o_flag_c = r_c;
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: random and directed commands against a behavioural register-file model
module tb_regfile_op_sequencer;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, cmd_ready;
  logic [2:0]  cmd_op = 0;
  logic [1:0]  cmd_ra = 0, cmd_rb = 0, cmd_rd = 0;
  logic [15:0] cmd_imm = 0;
  logic        done, err, flag_z, flag_c, rea, reb, we1, we2;
  logic [15:0] result, rda, rdb, wd1, wd2;
  logic [1:0]  raa, rab, wa1, wa2;
  logic [15:0] rf [4] = '{default: 16'h0};
  logic [15:0] ref_rf [4] = '{default: 16'h0};
  logic [15:0] ref_result = 0;
  logic        ref_z = 0, ref_c = 0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_ra(cmd_ra), .i_cmd_rb(cmd_rb), .i_cmd_rd(cmd_rd),
    .i_cmd_imm(cmd_imm), .o_done(done), .o_err(err), .o_result(result),
    .o_flag_z(flag_z), .o_flag_c(flag_c), .o_raa(raa), .o_rab(rab), .o_rea(rea),
    .o_reb(reb), .i_rda(rda), .i_rdb(rdb), .o_wa1(wa1), .o_wa2(wa2), .o_wd1(wd1),
    .o_wd2(wd2), .o_we1(we1), .o_we2(we2)
  );

  // Register file: reads are only valid while enabled, garbage otherwise
  assign rda = rea ? rf[raa] : 16'hDEAD;
  assign rdb = reb ? rf[rab] : 16'hBEEF;
  always @(posedge clk) begin
    if (we1) rf[wa1] <= wd1;
    if (we2) rf[wa2] <= wd2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_rf();
    return {rf[3], rf[2], rf[1], rf[0]};
  endfunction

  function automatic logic [63:0] pack_ref();
    return {ref_rf[3], ref_rf[2], ref_rf[1], ref_rf[0]};
  endfunction

  task automatic model(input logic [2:0] op, input logic [1:0] ra, rb, rd, input logic [15:0] imm);
    int a, b, s;
    a = ref_rf[ra];
    b = ref_rf[rb];
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
        case (op)
          3'd0: s = a + b;
          3'd1: s = a - b;
          3'd2: s = a & b;
          3'd3: s = a | b;
          default: s = a ^ b;
        endcase
        ref_rf[rd] = s[15:0];
        ref_result = s[15:0];
        ref_z = s[15:0] == 0;
        ref_c = op == 3'd0 ? s > 16'hFFFF : op == 3'd1 ? a < b : 1'b0;
      end
      3'd5: begin ref_rf[rd] = imm; ref_result = imm; end
      3'd6: begin ref_rf[ra] = b[15:0]; ref_rf[rb] = a[15:0]; ref_result = b[15:0]; end
      default: ;
    endcase
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic finish_cmd(input logic [2:0] op, input logic [1:0] ra, rb);
    int lat = 0, nre = 0, nw1 = 0, nw2 = 0;
    logic e = 0;
    do begin
      @(negedge clk);
      lat++;
      nre += int'(rea) + int'(reb);
      nw1 += int'(we1);
      nw2 += int'(we2);
      e = err;
    end while (!done && lat < 10);
    check("latency", lat, (op <= 3'd4 || op == 3'd6) ? 3 : 1);
    check("err", e, op == 3'd7);
    check("re_cycles", nre, (op <= 3'd4 || op == 3'd6) ? 2 : 0);
    check("we1_cycles", nw1, op != 3'd7);
    check("we2_cycles", nw2, op == 3'd6 && ra != rb);
    @(negedge clk);
    check("ready_after", cmd_ready, 1);
    check("done_pulse", done, 0);
    check("result", result, ref_result);
    check("flags", {flag_z, flag_c}, {ref_z, ref_c});
    check("regs", pack_rf(), pack_ref());
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] ra, rb, rd, input logic [15:0] imm);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1;
    wait_ready("cmd");
    @(posedge clk);
    #1 cmd_valid = 0;
    model(op, ra, rb, rd, imm);
    finish_cmd(op, ra, rb);
  endtask

  initial begin
    int gap;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_ctl", {done, err, rea, reb, we1, we2}, 0);
    check("rst_result", {result, flag_z, flag_c}, 0);
    check("rst_addr", {raa, rab, wa1, wa2, wd1, wd2}, 0);
    rst_n = 1;
    @(negedge clk);
    run_cmd(3'd5, 0, 0, 1, 16'h1234);
    run_cmd(3'd5, 0, 0, 2, 16'h0F0F);
    run_cmd(3'd0, 1, 2, 3, 0);
    check("add_r3", rf[3], 16'h2143);
    run_cmd(3'd1, 2, 1, 0, 0);
    check("sub_r0", {rf[0], flag_c}, {16'hFCDB, 1'b1});
    run_cmd(3'd5, 0, 0, 0, 16'hFFFF);
    run_cmd(3'd5, 0, 0, 3, 16'h0001);
    run_cmd(3'd0, 0, 3, 0, 0);
    check("add_wrap", {result, flag_z, flag_c}, {16'h0, 2'b11});
    run_cmd(3'd5, 0, 0, 3, 16'h2143);
    run_cmd(3'd6, 1, 2, 0, 0);
    check("swap", {rf[1], rf[2]}, {16'h0F0F, 16'h1234});
    run_cmd(3'd6, 3, 3, 0, 0);
    check("swap_same", rf[3], 16'h2143);
    run_cmd(3'd7, 1, 2, 3, 16'h5555);
    // three ADDs held back to back: ready drops for READ, EXEC and WB only
    cmd_op = 3'd0; cmd_ra = 1; cmd_rb = 2; cmd_rd = 0; cmd_valid = 1;
    wait_ready("b2b");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model(3'd0, 1, 2, 0, 0);
      if (k < 2) begin
        gap = 0;
        @(negedge clk);
        while (!cmd_ready && gap < 10) begin gap++; @(negedge clk); end
        check("b2b_gap", gap, 3);
      end
    end
    #1 cmd_valid = 0;
    finish_cmd(3'd0, 1, 2);
    // reset during EXEC: nothing written, everything back to reset values
    run_cmd(3'd5, 0, 0, 3, 16'h7777);
    cmd_op = 3'd0; cmd_ra = 1; cmd_rb = 2; cmd_rd = 3; cmd_valid = 1;
    wait_ready("abort");
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_ctl", {done, err, rea, reb, we1, we2, cmd_ready}, 7'b0000001);
    check("abort_out", {result, flag_z, flag_c}, 0);
    ref_result = 0; ref_z = 0; ref_c = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("abort_regs", pack_rf(), pack_ref());
    run_cmd(3'd0, 1, 2, 3, 0);
    for (int i = 0; i < 40; i++)
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
